// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug BRAM sequencer.
package dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RSTP,
        DRD,
        DWAIT,
        DOUT
    } dbgState_t;

    localparam logic [31:0] WORD_BYTES    = 32'd4;
    localparam logic [3:0]  WE_ALL        = 4'b1111;
    localparam int unsigned DEF_BRAMWORDS = 4096;

endpackage

// File: rtl/dbg_out_reg.sv
// Dump output holding register: captures one word with its address and
// keeps it stable until the downstream handshake.
module dbg_out_reg (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        capture,
    input  logic [31:0] capData,
    input  logic [31:0] capAddr,
    input  logic        capLast,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_data  <= capData;
            out_addr  <= capAddr;
            out_last  <= capLast;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dbg_bram_sequencer.sv
// Debug BRAM sequencer: loads a cache BRAM from a stream and pulses core
// reset, or dumps every BRAM word with its address to a stream.
module dbg_bram_sequencer
    import dbg_pkg::*;
#(
    parameter int unsigned BRAMWORDS  = DEF_BRAMWORDS,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned RST_CYCLES = 8
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        start_load,
    input  logic        start_dump,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] dbg_A2,
    output logic [31:0] dbg_WD2,
    output logic [3:0]  dbg_WE2,
    input  logic [31:0] dbg_RD2,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        core_rst,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW  = $clog2(BRAMWORDS) + 1;
    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

    dbgState_t      st;
    dbgState_t      stNext;
    logic [31:0]    addr;
    logic [CW-1:0]  cnt;
    logic [RCW-1:0] rstCnt;
    logic           inReadyQ;
    logic           busyQ;
    logic           coreRstQ;
    logic           doneQ;
    logic           loadAccept;
    logic           dumpTake;
    logic           lastWord;

    assign loadAccept = (st == LOAD) && in_valid;
    assign dumpTake   = (st == DOUT) && out_valid && out_ready;
    assign lastWord   = (cnt == CW'(BRAMWORDS - 1));

    always_comb begin
        stNext = st;
        case (st)
            IDLE: begin
                if (start_load)      stNext = LOAD;
                else if (start_dump) stNext = DRD;
            end
            LOAD:  if (loadAccept && (in_last || lastWord)) stNext = RSTP;
            RSTP:  if (rstCnt == '0) stNext = IDLE;
            DRD:   stNext = DWAIT;
            DWAIT: stNext = DOUT;
            DOUT:  if (dumpTake) stNext = out_last ? IDLE : DRD;
            default: stNext = IDLE;
        endcase
    end

    // dbg_A2 is updated on entry to DRD so the BRAM samples it at the end of
    // DRD and the read word is present during DWAIT.
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            st       <= IDLE;
            addr     <= BASE_ADDR;
            cnt      <= '0;
            rstCnt   <= '0;
            dbg_A2   <= BASE_ADDR;
            dbg_WD2  <= '0;
            dbg_WE2  <= '0;
            inReadyQ <= 1'b0;
            busyQ    <= 1'b0;
            coreRstQ <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            st       <= stNext;
            inReadyQ <= (stNext == LOAD);
            busyQ    <= (stNext != IDLE);
            coreRstQ <= (stNext != IDLE);
            doneQ    <= (st != IDLE) && (stNext == IDLE);
            dbg_WE2  <= '0;
            case (st)
                IDLE: begin
                    if (stNext != IDLE) begin
                        addr <= BASE_ADDR;
                        cnt  <= '0;
                    end
                    if (stNext == DRD) dbg_A2 <= BASE_ADDR;
                end
                LOAD: begin
                    if (loadAccept) begin
                        dbg_A2  <= addr;
                        dbg_WD2 <= in_data;
                        dbg_WE2 <= WE_ALL;
                        addr    <= addr + WORD_BYTES;
                        cnt     <= cnt + CW'(1);
                    end
                    if (stNext == RSTP) rstCnt <= RCW'(RST_CYCLES - 1);
                end
                RSTP: begin
                    if (rstCnt != '0) rstCnt <= rstCnt - RCW'(1);
                end
                DOUT: begin
                    if (dumpTake) begin
                        cnt  <= cnt + CW'(1);
                        addr <= addr + WORD_BYTES;
                        if (stNext == DRD) dbg_A2 <= addr + WORD_BYTES;
                    end
                end
                default: ;
            endcase
        end
    end

    dbg_out_reg outReg (
        .CPU_CLK   (CPU_CLK),
        .CPU_RST   (CPU_RST),
        .capture   (st == DWAIT),
        .capData   (dbg_RD2),
        .capAddr   (addr),
        .capLast   (lastWord),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign in_ready = inReadyQ;
    assign busy     = busyQ;
    assign done     = doneQ;
    assign core_rst = coreRstQ | CPU_RST;

endmodule

// File: tb/tb_dbg_bram_sequencer.sv
// Randomized bench for dbg_bram_sequencer against a word-level memory model.
module tb_dbg_bram_sequencer;

    localparam int unsigned WORDS = 4096;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int unsigned RSTC  = 8;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST;
    logic        start_load, start_dump;
    logic [31:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic [31:0] dbg_A2, dbg_WD2, dbg_RD2;
    logic [3:0]  dbg_WE2;
    logic [31:0] out_data, out_addr;
    logic        out_valid, out_last, out_ready;
    logic        core_rst, busy, done;

    logic [31:0] bram   [0:WORDS-1];
    logic [31:0] refMem [0:WORDS-1];

    int nChecks = 0;
    int nErrors = 0;

    always #5 CPU_CLK = ~CPU_CLK;

    dbg_bram_sequencer #(
        .BRAMWORDS  (WORDS),
        .BASE_ADDR  (BASE),
        .RST_CYCLES (RSTC)
    ) dut (
        .CPU_CLK    (CPU_CLK),
        .CPU_RST    (CPU_RST),
        .start_load (start_load),
        .start_dump (start_dump),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .dbg_A2     (dbg_A2),
        .dbg_WD2    (dbg_WD2),
        .dbg_WE2    (dbg_WE2),
        .dbg_RD2    (dbg_RD2),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous BRAM with byte enables and one-cycle read latency.
    always @(posedge CPU_CLK) begin
        for (int b = 0; b < 4; b++)
            if (dbg_WE2[b]) bram[dbg_A2[13:2]][8*b +: 8] <= dbg_WD2[8*b +: 8];
        dbg_RD2 <= bram[dbg_A2[13:2]];
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic runLoad(input int lastAt, input int gapPct, input bit fixedData,
                           input bit togglePat, input bit bothStart);
        int k = 0;
        int cyc = 0;
        int n = 0;
        bit inLoad = 1'b1;
        bit v;
        logic [31:0] d;
        start_load = 1'b1;
        start_dump = bothStart;
        tick();
        start_load = 1'b0;
        start_dump = 1'b0;
        checkVal("load_entry_ready", {31'b0, in_ready}, 32'd1);
        checkVal("load_entry_busy", {31'b0, busy}, 32'd1);
        checkVal("load_core_rst", {31'b0, core_rst}, 32'd1);
        while (inLoad && cyc < 20000) begin
            v = togglePat ? (cyc % 3 == 0) : ($urandom_range(99) >= gapPct);
            d = fixedData ? 32'(32'h11111111 * (k + 1)) : $urandom;
            in_valid = v;
            in_data  = d;
            in_last  = (k == lastAt);
            checkVal("in_ready", {31'b0, in_ready}, 32'd1);
            checkVal("no_out_valid", {31'b0, out_valid}, 32'd0);
            tick();
            if (v) begin
                checkVal("wr_we", {28'b0, dbg_WE2}, 32'hF);
                checkVal("wr_addr", dbg_A2, BASE + 32'(4 * k));
                checkVal("wr_data", dbg_WD2, d);
                refMem[k] = d;
                if (k == lastAt || k == WORDS - 1) inLoad = 1'b0;
                k++;
            end else begin
                checkVal("gap_we", {28'b0, dbg_WE2}, 32'h0);
            end
            cyc++;
        end
        checkVal("load_ended", {31'b0, inLoad}, 32'd0);
        // Offer one more word while the core is held in reset; it must be refused.
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'hDEADBEEF;
        checkVal("ready_drop", {31'b0, in_ready}, 32'd0);
        while (core_rst && n < 100) begin
            checkVal("rstp_we", {28'b0, dbg_WE2}, (n == 0) ? 32'hF : 32'h0);
            checkVal("rstp_ready", {31'b0, in_ready}, 32'd0);
            n++;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkVal("rst_len", n, RSTC);
        checkVal("load_done", {31'b0, done}, 32'd1);
        checkVal("load_idle", {31'b0, busy}, 32'd0);
        checkVal("load_no_out", {31'b0, out_valid}, 32'd0);
        tick();
        checkVal("load_done_pulse", {31'b0, done}, 32'd0);
        checkVal("load_idle_we", {28'b0, dbg_WE2}, 32'h0);
    endtask

    task automatic runDump(input int stallWord, input int stallLen, input bit randStall);
        int w;
        int stall;
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        checkVal("dump_busy", {31'b0, busy}, 32'd1);
        checkVal("dump_core_rst", {31'b0, core_rst}, 32'd1);
        checkVal("dump_no_ready", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < WORDS; k++) begin
            w = 0;
            while (!out_valid && w < 10) begin
                tick();
                w++;
            end
            checkVal("dump_valid", {31'b0, out_valid}, 32'd1);
            if (!out_valid) break;
            checkVal("dump_data", out_data, refMem[k]);
            checkVal("dump_addr", out_addr, BASE + 32'(4 * k));
            checkVal("dump_last", {31'b0, out_last}, {31'b0, k == WORDS - 1});
            checkVal("dump_we", {28'b0, dbg_WE2}, 32'h0);
            stall = (k == stallWord) ? stallLen : (randStall ? int'($urandom_range(2)) : 0);
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                tick();
                checkVal("stall_valid", {31'b0, out_valid}, 32'd1);
                checkVal("stall_data", out_data, refMem[k]);
                checkVal("stall_addr", out_addr, BASE + 32'(4 * k));
                checkVal("stall_a2", dbg_A2, BASE + 32'(4 * k));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (k == WORDS - 1) begin
                checkVal("dump_done", {31'b0, done}, 32'd1);
                checkVal("dump_idle", {31'b0, busy}, 32'd0);
            end else begin
                checkVal("dump_valid_drop", {31'b0, out_valid}, 32'd0);
                checkVal("dump_no_done", {31'b0, done}, 32'd0);
            end
        end
        tick();
        checkVal("dump_done_pulse", {31'b0, done}, 32'd0);
        checkVal("dump_core_rel", {31'b0, core_rst}, 32'd0);
    endtask

    task automatic resetMidLoad();
        logic [31:0] w [0:2];
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        // Word 2 has been accepted; its write is pending when reset hits.
        #2 CPU_RST = 1'b1;
        #1;
        checkVal("arst_we", {28'b0, dbg_WE2}, 32'h0);
        checkVal("arst_a2", dbg_A2, BASE);
        checkVal("arst_wd", dbg_WD2, 32'h0);
        checkVal("arst_ready", {31'b0, in_ready}, 32'd0);
        checkVal("arst_busy", {31'b0, busy}, 32'd0);
        checkVal("arst_core_rst", {31'b0, core_rst}, 32'd1);
        refMem[0] = w[0];
        refMem[1] = w[1];
        tick();
        CPU_RST = 1'b0;
        tick();
        checkVal("arst_rel_busy", {31'b0, busy}, 32'd0);
        checkVal("arst_rel_core", {31'b0, core_rst}, 32'd0);
        checkVal("arst_bram_w0", bram[0], refMem[0]);
        checkVal("arst_bram_w1", bram[1], refMem[1]);
        checkVal("arst_bram_w2", bram[2], refMem[2]);
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            bram[i]   = 32'hA5000000 | 32'(i);
            refMem[i] = 32'hA5000000 | 32'(i);
        end
        CPU_RST    = 1'b1;
        start_load = 1'b0;
        start_dump = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge CPU_CLK);
        #1;
        checkVal("rst_a2", dbg_A2, BASE);
        checkVal("rst_we", {28'b0, dbg_WE2}, 32'h0);
        checkVal("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkVal("rst_out_data", out_data, 32'h0);
        checkVal("rst_done", {31'b0, done}, 32'd0);
        checkVal("rst_core_rst", {31'b0, core_rst}, 32'd1);
        CPU_RST = 1'b0;
        tick();
        checkVal("idle_core_rst", {31'b0, core_rst}, 32'd0);
        checkVal("idle_busy", {31'b0, busy}, 32'd0);
        checkVal("idle_ready", {31'b0, in_ready}, 32'd0);

        runLoad(2, 0, 1'b1, 1'b0, 1'b0);
        runDump(2, 5, 1'b0);
        runLoad(1, 0, 1'b0, 1'b1, 1'b0);
        runLoad(5, 30, 1'b0, 1'b0, 1'b1);
        runLoad(-1, 10, 1'b0, 1'b0, 1'b0);
        resetMidLoad();
        runDump(-1, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
